// File: rtl/sm_1118_path_sequencer.sv
// Path sequencer: runs one node-to-node navigation command at a time.
// It follows the line on three IR sensors, confirms a node, and then does
// one of four things: crosses the node, turns at it, stops at it, or
// settles before and after switching the electromagnet.
// All outputs come straight from flops.
module sm_1118_path_sequencer #(
    parameter int NODE_DEB  = 4,
    parameter int CLEAR_CYC = 312500,
    parameter int BLIND_CYC = 625000,
    parameter int TURN_TO   = 6250000,
    parameter int LOST_CYC  = 1562500,
    parameter int EM_CYC    = 312500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sensor,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic       cmd_ready,
    output logic [3:0] direction,
    output logic       pickup,
    output logic       done,
    output logic       error
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared phase counter covers CROSS, BLIND, SEEK and both SETTLE states.
    localparam int CMAX = max2(max2(CLEAR_CYC, BLIND_CYC), max2(TURN_TO, EM_CYC));
    localparam int CW   = $clog2(CMAX + 1);
    localparam int NW   = $clog2(NODE_DEB + 1);
    localparam int LW   = $clog2(LOST_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FOLLOW, S_CROSS, S_BLIND, S_SEEK, S_SETTLE1, S_SETTLE2, S_ERR
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [NW-1:0] node_cnt, node_n, node_inc;
    logic [LW-1:0] lost_cnt, lost_n, lost_inc;
    logic [2:0]    cmd_q, cmd_n;
    logic [3:0]    dir_n;
    logic          pickup_n, done_n, error_n;

    // Each counter stops at its terminal count instead of wrapping.
    assign cnt_inc  = (cnt == CW'(CMAX))          ? cnt      : cnt + CW'(1);
    assign node_inc = (node_cnt == NW'(NODE_DEB)) ? node_cnt : node_cnt + NW'(1);
    assign lost_inc = (lost_cnt == LW'(LOST_CYC)) ? lost_cnt : lost_cnt + LW'(1);

    // Next-state logic, and next values for every registered output.
    always_comb begin
        state_n  = state;
        dir_n    = direction;
        pickup_n = pickup;
        done_n   = 1'b0;
        error_n  = error;
        cnt_n    = cnt;
        node_n   = node_cnt;
        lost_n   = lost_cnt;
        cmd_n    = cmd_q;
        case (state)
            S_IDLE: begin
                dir_n = 4'd0;
                if (cmd_valid && cmd_ready) begin
                    cmd_n  = cmd;
                    cnt_n  = '0;
                    node_n = '0;
                    lost_n = '0;
                    if (cmd <= 3'd4)       state_n = S_FOLLOW;
                    else if (cmd != 3'd7)  state_n = S_SETTLE1;
                    else                   done_n  = 1'b1;   // no-op command
                end
            end
            S_FOLLOW: begin
                node_n = (sensor == 3'b111) ? node_inc : '0;
                lost_n = (sensor == 3'b000) ? lost_inc : '0;
                case (sensor)
                    3'b010:         dir_n = 4'd1;
                    3'b110, 3'b100: dir_n = 4'd3;
                    3'b011, 3'b001: dir_n = 4'd2;
                    default:        dir_n = direction;  // 101, 000, 111 keep heading
                endcase
                if (sensor == 3'b111 && node_inc == NW'(NODE_DEB)) begin
                    cnt_n = '0;
                    case (cmd_q)
                        3'd0: begin state_n = S_CROSS; dir_n = 4'd1; end
                        3'd1: begin state_n = S_BLIND; dir_n = 4'd6; end
                        3'd2: begin state_n = S_BLIND; dir_n = 4'd5; end
                        3'd3: begin state_n = S_BLIND; dir_n = 4'd7; end
                        default: begin state_n = S_IDLE; dir_n = 4'd0; done_n = 1'b1; end
                    endcase
                end else if (sensor == 3'b000 && lost_inc == LW'(LOST_CYC)) begin
                    state_n = S_ERR;
                    dir_n   = 4'd0;
                    error_n = 1'b1;
                end
            end
            S_CROSS: begin
                dir_n = 4'd1;
                if (cnt == CW'(CLEAR_CYC - 1)) begin
                    state_n = S_IDLE; dir_n = 4'd0; done_n = 1'b1; cnt_n = '0;
                end else cnt_n = cnt_inc;
            end
            S_BLIND: begin
                // The spin code was set on entry. Sensors are ignored so the
                // line we are leaving is not taken as the target.
                if (cnt == CW'(BLIND_CYC - 1)) begin
                    state_n = S_SEEK; cnt_n = '0;
                end else cnt_n = cnt_inc;
            end
            S_SEEK: begin
                if (sensor[1]) begin
                    state_n = S_IDLE; dir_n = 4'd0; done_n = 1'b1; cnt_n = '0;
                end else if (cnt_inc == CW'(TURN_TO)) begin
                    state_n = S_ERR; dir_n = 4'd0; error_n = 1'b1;
                end else cnt_n = cnt_inc;
            end
            S_SETTLE1: begin
                dir_n = 4'd0;
                if (cnt == CW'(EM_CYC - 1)) begin
                    state_n  = S_SETTLE2;
                    pickup_n = (cmd_q == 3'd5);
                    cnt_n    = '0;
                end else cnt_n = cnt_inc;
            end
            S_SETTLE2: begin
                dir_n = 4'd0;
                if (cnt == CW'(EM_CYC - 1)) begin
                    state_n = S_IDLE; done_n = 1'b1; cnt_n = '0;
                end else cnt_n = cnt_inc;
            end
            default: begin  // S_ERR: parked until reset, magnet left as is
                dir_n   = 4'd0;
                error_n = 1'b1;
            end
        endcase
    end

    // State, counters and outputs. Reset clears everything, including the magnet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            node_cnt  <= '0;
            lost_cnt  <= '0;
            cmd_q     <= 3'd0;
            direction <= 4'd0;
            pickup    <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            node_cnt  <= node_n;
            lost_cnt  <= lost_n;
            cmd_q     <= cmd_n;
            direction <= dir_n;
            pickup    <= pickup_n;
            done      <= done_n;
            error     <= error_n;
            cmd_ready <= (state_n == S_IDLE);
        end
    end

endmodule
